sudoku_renderer: RTL and testbench
==================================

SUDOKU_RENDERER -- requirements
Module: sudoku_renderer

Interface
REQ-001 Parameter GRID_X0, default 104, left pixel column of the 432x432 grid (9 cells x 48 px).
REQ-002 Parameter GRID_Y0, default 24, top pixel row of the grid.
REQ-003 Ports; the block has one clock, and reset is asynchronous and active-high:
- clk25  in  1  25 MHz pixel clock
- reset  in  1  asynchronous, active-high
- hsync_in  in  1  timing-generator hsync, active-low
- vsync_in  in  1  timing-generator vsync, active-low
- video_on_in  in  1  visible-region flag
- x  in  10  pixel column 0-639
- y  in  10  pixel row 0-479
- board  in  324  81 cells x 4 bits; cell i = board[4i+3:4i]; i = row*9+col; 0 = empty, 1-9 = digit
- given_mask  in  81  bit i = 1 marks cell i as a puzzle given
- cursor_row  in  4  selected row, 0-8
- cursor_col  in  4  selected column, 0-8
- hsync  out  1  hsync_in delayed 2 cycles
- vsync  out  1  vsync_in delayed 2 cycles
- rgb  out  12  {R4,G4,B4} pixel colour

Function
REQ-004 Latency is exactly 2 clk25 cycles from (x, y, video_on_in, hsync_in, vsync_in) to the matching (rgb, hsync, vsync); sync and colour stay aligned.
REQ-005 Column tracker: col (4b, 9 = outside) and col_off (6b). Update rule:
- when video_on_in && x==GRID_X0-1: col=0, col_off=0
- else if col<9: col_off=47 wraps to 0 with col+1; otherwise col_off+1
- col=9 holds
REQ-006 Row tracker: row (4b, 9 = outside) and row_off (6b). Updates only when video_on_in && x==639, using the same rule with trigger y==GRID_Y0-1. Falling edge of vsync_in forces row=9.
REQ-007 No divider or multiplier on x/y; cell position comes only from the trackers.
REQ-008 Stage 1 classifies the pixel using the priority order below; stage 2 registers rgb.
- !video_on -> 12'h000
- (col==9 or row==9), excluding right and bottom edges -> 12'h222
- thick line -> 12'h000: off in {0,1} of cells 0, 3, 6; also x in {GRID_X0+432, GRID_X0+433} or y in {GRID_Y0+432, GRID_Y0+433} inside the grid span
- thin line -> 12'h888: off==0 of other cells
- glyph pixel -> 12'h000 if given, else 12'h00F
- cursor cell with blink on -> 12'hFE8
- otherwise 12'hFFF
REQ-009 Glyph: 8x8 font scaled x4, occupying offsets 8..39 in both axes; glyph row = (row_off-8)>>2, bit = 7-((col_off-8)>>2). Digit 0 or a value >9 draws nothing.
REQ-010 Blink: 5-bit frame_cnt increments on each falling edge of vsync_in and wraps 31->0; blink on when frame_cnt[4]==0.
REQ-011 A cursor_row or cursor_col value above 8 disables the highlight.
REQ-012 board, given_mask and cursor are sampled every cycle; mid-frame changes take effect on the next pixel.

Reset
REQ-013 On reset assertion, outputs go immediately to hsync=1, vsync=1, rgb=12'h000.
REQ-014 On reset assertion, col=9, row=9, offsets=0, frame_cnt=0, pipeline valid flags=0.
REQ-015 After reset release, the first correct grid appears in the first frame whose y==GRID_Y0-1 line completes.

Structure
REQ-016 Package sudoku_pkg holds: the colour constants, CELL_PX=48, GRID_PX=432, GLYPH_SCALE=4, and the pixel-class enum (BG, THICK, THIN, GLYPH, CURSOR, CELL).
REQ-017 Sub-module digit_rom is combinational, with inputs digit[3:0] and row[2:0] and output bits[7:0]; digits 0 and 10-15 return 8'h00.
REQ-018 Target size is 150-300 lines of RTL.

Verification
REQ-019 Reset mid-line -> next cycle hsync=1, vsync=1, rgb=0; after release, rgb at (GRID_X0, GRID_Y0) = 12'h000 (thick line) two cycles after that pixel is presented.
REQ-020 hsync_in low pulse at h=656..751 -> hsync low exactly h=658..753.
REQ-021 board cell 0 = 5, given_mask[0]=1 -> rgb 12'h000 on lit pixels of the '5' glyph in cell 0 and 12'hFFF on unlit ones; with given_mask[0]=0 the lit pixels are 12'h00F.
REQ-022 cursor (4,4) -> pixel (GRID_X0+4*48+2, GRID_Y0+4*48+2) = 12'hFE8 during frames 0-15 and 12'hFFF during frames 16-31; cursor (9,0) -> 12'hFFF in all frames.
REQ-023 Pixel (GRID_X0+3*48, GRID_Y0+100) = 12'h000; (GRID_X0+48, GRID_Y0+100) = 12'h888; (10, 10) = 12'h222.
REQ-024 32 vsync falling edges -> frame_cnt wraps to 0 and the blink phase restarts.

Source files
------------

// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared colours, geometry and pixel classes for the sudoku renderer.
package sudoku_pkg;
  localparam int CELL_PX = 48;
  localparam int GRID_PX = 432;
  localparam int GLYPH_SCALE = 4;
  localparam int GLYPH_OFF = 8;
  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_BG = 12'h222;
  localparam logic [11:0] C_THICK = 12'h000;
  localparam logic [11:0] C_THIN = 12'h888;
  localparam logic [11:0] C_GIVEN = 12'h000;
  localparam logic [11:0] C_USER = 12'h00F;
  localparam logic [11:0] C_CURSOR = 12'hFE8;
  localparam logic [11:0] C_CELL = 12'hFFF;
  typedef enum logic [2:0] {BG, THICK, THIN, GLYPH, CURSOR, CELL} pix_cls_t;
  function automatic logic [11:0] cls_rgb(input pix_cls_t c, input logic given);
    return c == BG ? C_BG : c == THIN ? C_THIN : c == GLYPH ? (given ? C_GIVEN : C_USER) :
           c == CURSOR ? C_CURSOR : c == CELL ? C_CELL : C_THICK;
  endfunction
endpackage

// File: rtl/sudoku_digit_rom.sv
// digit_rom: combinational 8x8 font for digits 1-9; other codes are blank.
module digit_rom (
  input  logic [3:0] digit,
  input  logic [2:0] row,
  output logic [7:0] bits
);
  localparam logic [63:0] FONT [16] = '{
    64'h0,
    64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00,
    64'h7E060C1830303000, 64'h3C66663C66663C00, 64'h3C66663E060C3800,
    64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0
  };
  logic [63:0] w_font;
  assign w_font = FONT[digit];
  // glyph row 0 sits in the most significant byte
  assign bits = w_font[{~row, 3'b000} +: 8];
endmodule

// File: rtl/sudoku_renderer.sv
// sudoku_renderer: two-stage pixel pipeline drawing a 9x9 sudoku board with grid, digits and a blinking cursor.
module sudoku_renderer
  import sudoku_pkg::*;
#(
  parameter int GRID_X0 = 104,
  parameter int GRID_Y0 = 24
) (
  input  logic         clk25,
  input  logic         reset,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic         video_on_in,
  input  logic [9:0]   x,
  input  logic [9:0]   y,
  input  logic [323:0] board,
  input  logic [80:0]  given_mask,
  input  logic [3:0]   cursor_row,
  input  logic [3:0]   cursor_col,
  output logic         hsync,
  output logic         vsync,
  output logic [11:0]  rgb
);
  localparam logic [9:0] X_TRIG = 10'(GRID_X0 - 1);
  localparam logic [9:0] Y_TRIG = 10'(GRID_Y0 - 1);
  localparam logic [9:0] X_E0 = 10'(GRID_X0 + GRID_PX);
  localparam logic [9:0] X_E1 = 10'(GRID_X0 + GRID_PX + 1);
  localparam logic [9:0] Y_E0 = 10'(GRID_Y0 + GRID_PX);
  localparam logic [9:0] Y_E1 = 10'(GRID_Y0 + GRID_PX + 1);
  localparam logic [5:0] OFF_LAST = 6'(CELL_PX - 1);
  localparam logic [5:0] G_LO = 6'(GLYPH_OFF);
  localparam logic [5:0] G_HI = 6'(GLYPH_OFF + 8 * GLYPH_SCALE);
  logic [3:0] r_col, r_row;
  logic [5:0] r_col_off, r_row_off;
  logic [4:0] r_frame;
  logic r_vs_prev, r_v1, r_hs1, r_vs1, r_von1, r_given1, r_hs2, r_vs2;
  pix_cls_t r_cls, w_cls;
  logic [11:0] r_rgb;
  logic w_vs_fall, w_in_x, w_in_y, w_edge, w_out, w_thick, w_thin, w_gin, w_lit, w_cur;
  logic [6:0] w_idx;
  logic [3:0] w_digit;
  logic [2:0] w_grow, w_gcol;
  logic [7:0] w_bits;
  assign w_vs_fall = r_vs_prev & ~vsync_in;
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_col <= 4'd9;
      r_row <= 4'd9;
      r_col_off <= '0;
      r_row_off <= '0;
      r_frame <= '0;
      r_vs_prev <= 1'b0;
    end else begin
      r_vs_prev <= vsync_in;
      if (w_vs_fall) r_frame <= r_frame + 5'd1;
      if (video_on_in && x == X_TRIG) begin
        r_col <= '0;
        r_col_off <= '0;
      end else if (r_col < 4'd9) begin
        r_col_off <= (r_col_off == OFF_LAST) ? 6'd0 : r_col_off + 6'd1;
        if (r_col_off == OFF_LAST) r_col <= r_col + 4'd1;
      end
      if (w_vs_fall) r_row <= 4'd9;
      else if (video_on_in && x == 10'd639) begin
        if (y == Y_TRIG) begin
          r_row <= '0;
          r_row_off <= '0;
        end else if (r_row < 4'd9) begin
          r_row_off <= (r_row_off == OFF_LAST) ? 6'd0 : r_row_off + 6'd1;
          if (r_row_off == OFF_LAST) r_row <= r_row + 4'd1;
        end
      end
    end
  end
  // cell index from trackers: row*9 + col built from a shift and adds
  assign w_idx = {r_row, 3'b000} + {3'b000, r_row} + {3'b000, r_col};
  assign w_digit = board[{w_idx, 2'b00} +: 4];
  assign w_grow = 3'((r_row_off - G_LO) >> 2);
  assign w_gcol = 3'((r_col_off - G_LO) >> 2);
  digit_rom u_rom (.digit(w_digit), .row(w_grow), .bits(w_bits));
  assign w_in_x = x >= 10'(GRID_X0) && x <= X_E1;
  assign w_in_y = y >= 10'(GRID_Y0) && y <= Y_E1;
  assign w_edge = ((x == X_E0 || x == X_E1) && w_in_y) || ((y == Y_E0 || y == Y_E1) && w_in_x);
  assign w_out = r_col == 4'd9 || r_row == 4'd9;
  assign w_thick = w_edge || ((r_col == 4'd0 || r_col == 4'd3 || r_col == 4'd6) && r_col_off < 6'd2) ||
                   ((r_row == 4'd0 || r_row == 4'd3 || r_row == 4'd6) && r_row_off < 6'd2);
  assign w_thin = r_col_off == 6'd0 || r_row_off == 6'd0;
  assign w_gin = r_col_off >= G_LO && r_col_off < G_HI && r_row_off >= G_LO && r_row_off < G_HI;
  assign w_lit = w_gin && w_bits[~w_gcol];
  assign w_cur = cursor_row < 4'd9 && cursor_col < 4'd9 && r_row == cursor_row && r_col == cursor_col && !r_frame[4];
  always_comb begin
    w_cls = (w_out && !w_edge) ? BG : w_thick ? THICK : w_thin ? THIN : w_lit ? GLYPH : w_cur ? CURSOR : CELL;
  end
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
      r_von1 <= 1'b0;
      r_given1 <= 1'b0;
      r_cls <= BG;
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
      r_rgb <= C_BLACK;
    end else begin
      r_v1 <= 1'b1;
      r_hs1 <= hsync_in;
      r_vs1 <= vsync_in;
      r_von1 <= video_on_in;
      r_given1 <= given_mask[w_idx];
      r_cls <= w_cls;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_rgb <= (r_v1 && r_von1) ? cls_rgb(r_cls, r_given1) : C_BLACK;
    end
  end
  assign hsync = r_hs2;
  assign vsync = r_vs2;
  assign rgb = r_rgb;
endmodule

// File: tb/tb_sudoku_renderer.sv
// tb_sudoku_renderer: directed checks of grid, glyph, cursor blink, sync delay and reset behaviour.
module tb_sudoku_renderer;
  localparam int X0 = 104;
  localparam int Y0 = 24;
  logic clk25 = 1'b0;
  logic reset, hsync_in, vsync_in, video_on_in, hsync, vsync;
  logic [9:0] x, y;
  logic [323:0] board;
  logic [80:0] given_mask;
  logic [3:0] cursor_row, cursor_col;
  logic [11:0] rgb, got;
  int n_cmp = 0, n_bad = 0, exp_frames = 0;
  int hs_first, hs_last, hs_cnt, vs_first;
  sudoku_renderer #(.GRID_X0(X0), .GRID_Y0(Y0)) dut (
    .clk25(clk25), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .video_on_in(video_on_in), .x(x), .y(y), .board(board), .given_mask(given_mask),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );
  always #20 clk25 = ~clk25;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk25);
    #1;
  endtask
  task automatic set_idle;
    video_on_in = 1'b0;
    x = '0;
    y = '0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
  endtask
  // one abbreviated frame: vsync pulse, row advance lines, then a line swept up to the pixel
  task automatic show_pixel(input int px, input int py, output logic [11:0] res);
    set_idle;
    vsync_in = 1'b0;
    step;
    vsync_in = 1'b1;
    step;
    exp_frames++;
    if (py >= Y0) begin
      video_on_in = 1'b1;
      x = 10'd639;
      y = 10'(Y0 - 1);
      step;
      for (int yy = Y0; yy < py; yy++) begin
        y = 10'(yy);
        step;
      end
    end
    video_on_in = 1'b1;
    y = 10'(py);
    for (int xx = (px >= X0 ? X0 - 1 : px); xx <= px; xx++) begin
      x = 10'(xx);
      step;
    end
    x = 10'(px + 1);
    step;
    res = rgb;
    set_idle;
  endtask
  initial begin
    reset = 1'b1;
    set_idle;
    board = '0;
    board[3:0] = 4'd5;
    given_mask = '0;
    cursor_row = 4'd9;
    cursor_col = 4'd0;
    repeat (3) step;
    reset = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (4) step;
    check("hs_pre", hsync, 0);
    #7 reset = 1'b1;
    #1;
    check("rst_hs", hsync, 1);
    check("rst_vs", vsync, 1);
    check("rst_rgb", rgb, 12'h000);
    set_idle;
    repeat (2) step;
    reset = 1'b0;
    exp_frames = 0;
    step;
    show_pixel(X0, Y0, got);
    check("corner", got, 12'h000);
    hs_first = -1;
    hs_last = -1;
    hs_cnt = 0;
    vs_first = -1;
    for (int h = 0; h < 802; h++) begin
      hsync_in = !(h >= 656 && h <= 751);
      vsync_in = hsync_in;
      x = 10'(h < 640 ? h : 0);
      step;
      if (!hsync) begin
        if (hs_first < 0) hs_first = h + 1;
        hs_last = h + 1;
        hs_cnt++;
      end
      if (!vsync && vs_first < 0) vs_first = h + 1;
    end
    exp_frames++;
    set_idle;
    check("hs_first", hs_first, 658);
    check("hs_last", hs_last, 753);
    check("hs_cnt", hs_cnt, 96);
    check("vs_first", vs_first, 658);
    given_mask[0] = 1'b1;
    show_pixel(X0 + 14, Y0 + 9, got);
    check("g5_lit", got, 12'h000);
    show_pixel(X0 + 9, Y0 + 9, got);
    check("g5_unlit", got, 12'hFFF);
    show_pixel(X0 + 34, Y0 + 20, got);
    check("g5_lit_r3", got, 12'h000);
    given_mask[0] = 1'b0;
    show_pixel(X0 + 14, Y0 + 9, got);
    check("g5_user", got, 12'h00F);
    show_pixel(X0 + 144, Y0 + 100, got);
    check("thick_c3", got, 12'h000);
    show_pixel(X0 + 48, Y0 + 100, got);
    check("thin_c1", got, 12'h888);
    show_pixel(10, 10, got);
    check("bg_10_10", got, 12'h222);
    show_pixel(X0 + 432, Y0 + 100, got);
    check("edge_r", got, 12'h000);
    show_pixel(X0 + 434, Y0 + 100, got);
    check("past_r", got, 12'h222);
    show_pixel(X0 + 100, Y0 + 433, got);
    check("edge_b", got, 12'h000);
    for (int i = 0; i < 40; i++) begin
      cursor_row = (i % 2 == 0) ? 4'd4 : 4'd9;
      cursor_col = (i % 2 == 0) ? 4'd4 : 4'd0;
      show_pixel(X0 + 4 * 48 + 2, Y0 + 4 * 48 + 2, got);
      check((i % 2 == 0) ? "blink_44" : "cursor_90", got,
            (i % 2 == 0 && (exp_frames % 32) < 16) ? 12'hFE8 : 12'hFFF);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
